// File: rtl/sobel_frame_sequencer.sv
// Sobel frame sequencer: captures one N x M frame of 8-bit pixels in raster
// order, then presents every 3x3 window of that frame to a downstream
// convolution datapath with valid/ready handshaking, one window per cycle.
module sobel_frame_sequencer #(
  parameter int N = 5,
  parameter int M = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [71:0] win_data,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [7:0]  win_row,
  output logic [7:0]  win_col,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic [1:0]  state
);

  localparam int DEPTH = N * M;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);
  localparam logic [7:0]    LAST_C   = 8'(M - 3);
  localparam logic [7:0]    LAST_R   = 8'(N - 3);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    SCAN = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t        st;
  logic [AW-1:0] widx;
  logic [7:0]    r;
  logic [7:0]    c;
  logic [7:0]    fcnt;
  logic [7:0]    mem [DEPTH];
  logic          accept;

  // Pixels are taken only while the frame buffer is being (re)filled.
  assign din_ready   = (st == IDLE) || (st == FILL);
  assign accept      = din_valid && din_ready;
  assign win_valid   = (st == SCAN);
  assign frame_done  = (st == DONE);
  assign win_row     = r;
  assign win_col     = c;
  assign frame_count = fcnt;
  assign state       = st;

  // Control FSM: fill the buffer, walk the window grid, pulse done, repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      widx <= '0;
      r    <= '0;
      c    <= '0;
      fcnt <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          // widx is already 0 here, so the write side stores pixel 0 at index 0.
          if (accept) begin
            widx <= ONE_IDX;
            st   <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (widx == LAST_IDX) begin
              widx <= '0;
              r    <= '0;
              c    <= '0;
              st   <= SCAN;
            end else begin
              widx <= widx + ONE_IDX;
            end
          end
        end
        SCAN: begin
          if (win_ready) begin
            if (c == LAST_C) begin
              c <= '0;
              if (r == LAST_R) begin
                r  <= '0;
                st <= DONE;
              end else begin
                r <= r + 8'd1;
              end
            end else begin
              c <= c + 8'd1;
            end
          end
        end
        DONE: begin
          fcnt <= fcnt + 8'd1;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Frame buffer write port; contents are not reset since a new frame overwrites them.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[widx] <= din;
    end
  end

  // Window gather: nine buffer reads around (r, c); forced to zero outside SCAN.
  always_comb begin
    win_data = '0;
    if (st == SCAN) begin
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = 0; dc < 3; dc++) begin
          win_data[8*(3*dr+dc) +: 8] = mem[AW'((int'(r) + dr) * M + int'(c) + dc)];
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: a frame-level reference model checked every
// cycle, directed scenarios with literal expectations, and a 3x3 instance.
module tb_sobel_frame_sequencer;

  localparam int NN = 5;
  localparam int MM = 5;
  localparam int NW = (NN - 2) * (MM - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [71:0] win_data;
  logic        win_valid;
  logic        win_ready = 1'b1;
  logic [7:0]  win_row, win_col;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic [1:0]  state;

  logic [7:0]  d3_din = 8'd0;
  logic        d3_valid = 1'b0;
  logic        d3_din_ready;
  logic [71:0] d3_win_data;
  logic        d3_win_valid;
  logic        d3_win_ready = 1'b1;
  logic [7:0]  d3_win_row, d3_win_col;
  logic        d3_frame_done;
  logic [7:0]  d3_frame_count;
  logic [1:0]  d3_state;

  sobel_frame_sequencer #(.N(NN), .M(MM)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done),
    .frame_count(frame_count), .state(state)
  );

  sobel_frame_sequencer #(.N(3), .M(3)) dut3 (
    .clk(clk), .rst(rst), .din(d3_din), .din_valid(d3_valid), .din_ready(d3_din_ready),
    .win_data(d3_win_data), .win_valid(d3_win_valid), .win_ready(d3_win_ready),
    .win_row(d3_win_row), .win_col(d3_win_col), .frame_done(d3_frame_done),
    .frame_count(d3_frame_count), .state(d3_state)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = taking pixels, 1 = scanning, 2 = done pulse.
  logic [7:0] m_img [NN*MM];
  int m_ph = 0;
  int m_cnt = 0;
  int m_win = 0;
  int m_frames = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_cnt <= 0; m_win <= 0; m_frames <= 0;
    end else begin
      case (m_ph)
        0: if (din_valid) begin
             m_img[m_cnt] <= din;
             if (m_cnt == NN*MM - 1) begin m_ph <= 1; m_cnt <= 0; m_win <= 0; end
             else m_cnt <= m_cnt + 1;
           end
        1: if (win_ready) begin
             if (m_win == NW - 1) m_ph <= 2;
             else m_win <= m_win + 1;
           end
        default: begin m_frames <= (m_frames + 1) % 256; m_ph <= 0; end
      endcase
    end
  end

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] e;
    e = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        e[8*(3*dr+dc) +: 8] = m_img[(r + dr) * MM + c + dc];
    return e;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state", 72'(state),
          72'((m_ph == 1) ? 2 : (m_ph == 2) ? 3 : (m_cnt == 0) ? 0 : 1));
      chk("m_din_ready", 72'(din_ready), 72'(m_ph == 0));
      chk("m_win_valid", 72'(win_valid), 72'(m_ph == 1));
      chk("m_frame_done", 72'(frame_done), 72'(m_ph == 2));
      chk("m_frame_count", 72'(frame_count), 72'(m_frames));
      if (m_ph == 1) begin
        chk("m_win_row", 72'(win_row), 72'(m_win / (MM - 2)));
        chk("m_win_col", 72'(win_col), 72'(m_win % (MM - 2)));
        chk("m_win_data", win_data, exp_win(m_win / (MM - 2), m_win % (MM - 2)));
      end
    end
  end

  // Feed one frame; optional gap after each pixel; optionally keep din_valid high afterwards.
  task automatic fill(input int base, input bit gaps, input bit hold);
    for (int i = 0; i < NN*MM; i++) begin
      din = 8'(base + i);
      din_valid = 1'b1;
      @(negedge clk);
      if (gaps && i < NN*MM - 1) begin
        din_valid = 1'b0;
        din = 8'hA5;
        @(negedge clk);
      end
    end
    din_valid = hold;
    din = 8'hEE;
  endtask

  // Run the scan until frame_done is seen, optionally stalling 4 cycles at step stall_at.
  task automatic scan(input int stall_at, input logic [71:0] stall_exp);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      win_ready = !(stall_at >= 0 && k >= stall_at && k < stall_at + 4);
      if (stall_at >= 0 && k >= stall_at && k <= stall_at + 4) begin
        chk("stall_row", 72'(win_row), 72'd1);
        chk("stall_col", 72'(win_col), 72'd1);
        chk("stall_data", win_data, stall_exp);
      end
      if (frame_done) begin
        seen = 1'b1;
        din_valid = 1'b0;
      end
      @(negedge clk);
    end
    win_ready = 1'b1;
    if (!seen) chk("scan_timeout", 72'd0, 72'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_din_ready", 72'(din_ready), 72'd1);
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_frame_done", 72'(frame_done), 72'd0);
    chk("rst_win_row", 72'(win_row), 72'd0);
    chk("rst_win_col", 72'(win_col), 72'd0);
    chk("rst_win_data", win_data, 72'd0);
    chk("rst_state", 72'(state), 72'd0);
    chk("rst_frame_count", 72'(frame_count), 72'd0);

    // Frame A: pixels 0..24 back-to-back, no stalls.
    fill(0, 1'b0, 1'b0);
    chk("a_first_data", win_data, 72'h0C0B0A070605020100);
    chk("a_first_rc", 72'({win_row, win_col}), 72'h0000);
    repeat (8) @(negedge clk);
    chk("a_last_data", win_data, 72'h1817161312110E0D0C);
    chk("a_last_rc", 72'({win_row, win_col}), 72'h0202);
    @(negedge clk);
    chk("a_done_t10", 72'(frame_done), 72'd1);
    @(negedge clk);
    chk("a_count", 72'(frame_count), 72'd1);
    chk("a_idle", 72'(state), 72'd0);

    // Frame B: gapped fill, din_valid held through scan, 4-cycle stall at (1,1).
    fill(100, 1'b1, 1'b1);
    scan(4, 72'h76757471706F6C6B6A);
    chk("b_count", 72'(frame_count), 72'd2);

    // Partial fill discarded by reset.
    for (int i = 0; i < 10; i++) begin
      din = 8'(i + 77);
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("fillrst_state", 72'(state), 72'd0);

    // Frame C: reset while the window sits at (1,2).
    fill(50, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("c_at_1_2", 72'({win_row, win_col}), 72'h0102);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("c_rst_state", 72'(state), 72'd0);
    chk("c_rst_win_valid", 72'(win_valid), 72'd0);
    chk("c_rst_din_ready", 72'(din_ready), 72'd1);
    chk("c_rst_count", 72'(frame_count), 72'd0);

    // Frame D: full frame after reset scans from (0,0).
    fill(200, 1'b0, 1'b0);
    chk("d_first_rc", 72'({win_row, win_col}), 72'h0000);
    chk("d_first_data", win_data, 72'hD4D3D2CFCECDCAC9C8);
    scan(-1, 72'd0);
    chk("d_count", 72'(frame_count), 72'd1);

    // 255 more frames: 256 frames since reset wrap the counter to 0.
    for (int f = 0; f < 255; f++) begin
      fill(f * 3, 1'b0, 1'b0);
      scan(-1, 72'd0);
      if (f == 253) chk("wrap_255", 72'(frame_count), 72'd255);
    end
    chk("wrap_0", 72'(frame_count), 72'd0);

    // 3x3 instance: single window, done on the next cycle.
    for (int i = 9; i <= 17; i++) begin
      d3_din = 8'(i);
      d3_valid = 1'b1;
      @(negedge clk);
    end
    d3_valid = 1'b0;
    chk("n3_valid", 72'(d3_win_valid), 72'd1);
    chk("n3_data", d3_win_data, 72'h11100F0E0D0C0B0A09);
    chk("n3_rc", 72'({d3_win_row, d3_win_col}), 72'h0000);
    @(negedge clk);
    chk("n3_done", 72'(d3_frame_done), 72'd1);
    chk("n3_valid_off", 72'(d3_win_valid), 72'd0);
    @(negedge clk);
    chk("n3_count", 72'(d3_frame_count), 72'd1);
    chk("n3_idle", 72'(d3_state), 72'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_frame_sequencer.md
SOBEL_FRAME_SEQUENCER -- requirements
Module: sobel_frame_sequencer

Parameters
REQ-001 N, 5, image rows; legal range 3..256.
REQ-002 M, 5, image columns; legal range 3..256.

Interface
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  8  incoming pixel, raster order, one byte per pixel.
REQ-006 din_valid  input  1  din carries a pixel this cycle.
REQ-007 din_ready  output  1  block accepts a pixel this cycle.
REQ-008 win_data  output  72  3x3 window; byte k = win_data[8k+7:8k], k = 3*dr+dc.
REQ-009 win_valid  output  1  win_data holds a valid window.
REQ-010 win_ready  input  1  downstream convolution datapath takes the window this cycle.
REQ-011 win_row  output  8  top-left row r of the current window.
REQ-012 win_col  output  8  top-left column c of the current window.
REQ-013 frame_done  output  1  one-cycle pulse after the last window of a frame is taken.
REQ-014 frame_count  output  8  count of completed frames.
REQ-015 state  output  2  FSM state: IDLE=00, FILL=01, SCAN=10, DONE=11.

Function
REQ-016 The block SHALL hold an internal N*M-byte frame buffer indexed row*M+col.
REQ-017 A pixel SHALL be accepted only in a cycle where din_valid=1 and din_ready=1.
REQ-018 din_ready SHALL be 1 in IDLE and FILL, and 0 in SCAN and DONE.
REQ-019 din_valid in SCAN or DONE SHALL be ignored; no buffer write, no state change.
REQ-020 IDLE: an accepted pixel SHALL be written to index 0 and the FSM SHALL move to FILL; no accept keeps IDLE.
REQ-021 FILL: each accepted pixel SHALL be written to the next index, and gap cycles SHALL leave the write index unchanged.
REQ-022 Acceptance of pixel N*M-1 SHALL move the FSM to SCAN on the next cycle, with window counters at r=0, c=0.
REQ-023 In SCAN, win_valid SHALL be 1 and win_data byte 3*dr+dc SHALL equal buf[(r+dr)*M + c+dc], for dr,dc in 0..2.
REQ-024 The window SHALL advance only in a cycle where win_valid=1 and win_ready=1, with at most one window per cycle.
REQ-025 Window advance order: c increments; at c=M-3, c wraps to 0 and r increments. The scan SHALL produce (N-2)*(M-2) windows in total.
REQ-026 While win_ready=0, win_data, win_row and win_col SHALL hold stable.
REQ-027 Acceptance of window (N-3, M-3) SHALL move the FSM to DONE; DONE SHALL last exactly one cycle with frame_done=1, then go to IDLE.
REQ-028 frame_count SHALL increment by 1 on each DONE cycle and wrap from 255 to 0.
REQ-029 win_valid SHALL be 0 and frame_done SHALL be 0 outside SCAN and DONE respectively.
REQ-030 Buffer contents SHALL remain unchanged from entry to SCAN until the FSM returns to IDLE.
REQ-031 When win_valid=0, win_data, win_row and win_col are don't-care but SHALL not be X after reset.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE and clear the write index, r, c and frame_count to 0. This SHALL hold from any state, including mid-FILL and mid-SCAN.
REQ-033 After reset, outputs SHALL be: din_ready=1, win_valid=0, frame_done=0, win_row=0, win_col=0, win_data=0, state=00.
REQ-034 Buffer contents need not be cleared by reset; a partially filled frame SHALL be discarded.

Verification
REQ-035 N=M=5, pixels 0..24 back-to-back, win_ready=1. Expected: 9 windows in consecutive cycles; first win_data bytes 0,1,2,5,6,7,10,11,12; last bytes 12,13,14,17,18,19,22,23,24; if pixel 24 is accepted at cycle t, frame_done=1 at t+10 and frame_count=1.
REQ-036 Backpressure: win_ready=0 for 4 cycles at window (1,1). Expected: win_data, win_row=1 and win_col=1 stable for those cycles; no window skipped or repeated.
REQ-037 din_valid toggling 1/0 during FILL, plus din_valid=1 held through SCAN. Expected: exactly 25 pixels stored; din_ready=0 and no buffer change during SCAN.
REQ-038 rst=1 during SCAN at window (1,2). Expected: next cycle state=00, win_valid=0, din_ready=1, frame_count=0; a following full frame scans correctly from (0,0).
REQ-039 N=M=3, pixels 9..17. Expected: a single window with bytes 9..17, frame_done on the next cycle.
REQ-040 256 consecutive frames. Expected: frame_count wraps to 0 on the 256th DONE.
